// File: rtl/dlf_kcounter_if.sv
// Control/status bundle between the DPLL phase detector / K control and the
// K-counter loop filter.
//   enable  : count strobe
//   dirSig  : 0 = count up (lead), 1 = count down (lag)
//   kMode   : requested K, sampled while kLoad=1
//   kLoad   : load kMode into the K register
//   carry   : one-cycle pulse on up-wrap
//   borrow  : one-cycle pulse on down-wrap
//   kTop    : current terminal count 2^(k+1)-1
//   count   : counter value (debug)
//   lock    : loop locked
// Modports: master drives the controls and observes status; slave is the filter.
interface dlf_kcounter_if #(
  parameter int CNT_W  = 20,
  parameter int MODE_W = 5
);
  logic              enable;
  logic              dirSig;
  logic [MODE_W-1:0] kMode;
  logic              kLoad;
  logic              carry;
  logic              borrow;
  logic [CNT_W-1:0]  kTop;
  logic [CNT_W-1:0]  count;
  logic              lock;

  modport master (
    output enable, dirSig, kMode, kLoad,
    input  carry, borrow, kTop, count, lock
  );

  modport slave (
    input  enable, dirSig, kMode, kLoad,
    output carry, borrow, kTop, count, lock
  );
endinterface

// File: rtl/dlf_kcounter.sv
// Parametrised K-counter digital loop filter for the DPLL.
// Integrates the phase-detector direction in an up/down counter of modulus
// 2^(k+1) and emits registered one-cycle carry (advance) / borrow (retard)
// pulses. K is runtime-loadable and clamped to [K_MIN, K_MAX].
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : dlf_kcounter_if.slave (enable, dirSig, kMode, kLoad in;
//           carry, borrow, kTop, count, lock out)
// Optional feature: define LOCK_DET_EN to build the lock detector
// (lock asserts after LOCK_CNT enabled cycles without a wrap); otherwise
// lock is tied to 0.
module dlf_kcounter #(
  parameter int CNT_W    = 20,
  parameter int MODE_W   = 5,
  parameter int K_MIN    = 2,
  parameter int K_MAX    = 19,
  parameter int K_INIT   = 2,
  parameter int RST_MID  = 0,
  parameter int LOCK_CNT = 1024
) (
  input  logic           clk,
  input  logic           reset,
  dlf_kcounter_if.slave  bus
);

  if (K_MAX > CNT_W - 1) begin : g_kmax_chk
    $error("dlf_kcounter: K_MAX must not exceed CNT_W-1");
  end
  if (K_MIN > K_MAX || K_INIT < K_MIN || K_INIT > K_MAX) begin : g_kinit_chk
    $error("dlf_kcounter: K_MIN <= K_INIT <= K_MAX required");
  end
  if (LOCK_CNT < 1) begin : g_lock_chk
    $error("dlf_kcounter: LOCK_CNT must be at least 1");
  end

  function automatic logic [CNT_W-1:0] top_of(input logic [MODE_W-1:0] kv);
    logic [CNT_W-1:0] ones;
    int unsigned      sh;
    ones = '1;
    sh   = int'(CNT_W - 1) - int'(kv);
    return ones >> sh;
  endfunction

  function automatic logic [CNT_W-1:0] rst_val_of(input logic [MODE_W-1:0] kv);
    return (RST_MID != 0) ? (top_of(kv) >> 1) : '0;
  endfunction

  logic [MODE_W-1:0] k_q, k_d, k_clamp;
  logic [CNT_W-1:0]  cnt_q, cnt_d, top;
  logic              carry_q, carry_d, borrow_q, borrow_d;

  assign top = top_of(k_q);

  always_comb begin
    if (int'(bus.kMode) < K_MIN)      k_clamp = MODE_W'(K_MIN);
    else if (int'(bus.kMode) > K_MAX) k_clamp = MODE_W'(K_MAX);
    else                              k_clamp = bus.kMode;
  end

  // kLoad wins over enable and suppresses any wrap pulse on that edge.
  always_comb begin
    k_d      = k_q;
    cnt_d    = cnt_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    if (bus.kLoad) begin
      k_d   = k_clamp;
      cnt_d = rst_val_of(k_clamp);
    end else if (bus.enable) begin
      if (!bus.dirSig) begin
        if (cnt_q == top) begin
          cnt_d   = '0;
          carry_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        if (cnt_q == '0) begin
          cnt_d    = top;
          borrow_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_q      <= MODE_W'(K_INIT);
      cnt_q    <= rst_val_of(MODE_W'(K_INIT));
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  assign bus.carry  = carry_q;
  assign bus.borrow = borrow_q;
  assign bus.kTop   = top;
  assign bus.count  = cnt_q;

`ifdef LOCK_DET_EN
  localparam int QW = $clog2(LOCK_CNT + 1);

  logic [QW-1:0] quiet_q;
  logic          lock_q;
  logic          clr;

  assign clr = bus.kLoad | carry_d | borrow_d;

  // Quiet counter saturates at LOCK_CNT; lock follows one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quiet_q <= '0;
      lock_q  <= 1'b0;
    end else if (clr) begin
      quiet_q <= '0;
      lock_q  <= 1'b0;
    end else begin
      if (bus.enable && quiet_q != QW'(LOCK_CNT))
        quiet_q <= quiet_q + 1'b1;
      if (quiet_q == QW'(LOCK_CNT))
        lock_q <= 1'b1;
    end
  end

  assign bus.lock = lock_q;
`else
  assign bus.lock = 1'b0;
`endif

endmodule

// File: tb/tb_dlf_kcounter.sv
// Directed bench for dlf_kcounter: dut0 uses defaults (K_INIT=2, RST_MID=0),
// dut1 uses K_INIT=3, RST_MID=1. Both use LOCK_CNT=16 for the lock checks.
module tb_dlf_kcounter;
  localparam int CNT_W  = 20;
  localparam int MODE_W = 5;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  dlf_kcounter_if #(.CNT_W(CNT_W), .MODE_W(MODE_W)) bus0 ();
  dlf_kcounter_if #(.CNT_W(CNT_W), .MODE_W(MODE_W)) bus1 ();

  dlf_kcounter #(.CNT_W(CNT_W), .MODE_W(MODE_W), .LOCK_CNT(16)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  dlf_kcounter #(.CNT_W(CNT_W), .MODE_W(MODE_W), .K_INIT(3), .RST_MID(1),
                 .LOCK_CNT(16)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic en, input logic dir, input logic ld, input logic [4:0] km);
    bus0.enable = en; bus0.dirSig = dir; bus0.kLoad = ld; bus0.kMode = km;
  endtask

  task automatic drive1(input logic en, input logic dir, input logic ld, input logic [4:0] km);
    bus1.enable = en; bus1.dirSig = dir; bus1.kLoad = ld; bus1.kMode = km;
  endtask

  initial begin
    drive0(1'b0, 1'b0, 1'b0, 5'd0);
    drive1(1'b0, 1'b0, 1'b0, 5'd0);
    reset = 1'b1;
    #12;
    check_eq("rst0_count", bus0.count, 0);
    check_eq("rst0_ktop", bus0.kTop, 7);
    check_eq("rst0_carry", bus0.carry, 0);
    check_eq("rst0_borrow", bus0.borrow, 0);
    check_eq("rst0_lock", bus0.lock, 0);
    check_eq("rst1_count", bus1.count, 7);
    check_eq("rst1_ktop", bus1.kTop, 15);
    reset = 1'b0;
    tick();
    check_eq("idle0_count", bus0.count, 0);

    // 1: eight up cycles, carry only after the 7->0 wrap
    drive0(1'b1, 1'b0, 1'b0, 5'd0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check_eq("up_count", bus0.count, i % 8);
      check_eq("up_carry", bus0.carry, (i == 8) ? 1 : 0);
      check_eq("up_borrow", bus0.borrow, 0);
    end

    // 2: down from 0 wraps to 7 with one borrow
    drive0(1'b1, 1'b1, 1'b0, 5'd0);
    tick();
    check_eq("dn_wrap_count", bus0.count, 7);
    check_eq("dn_wrap_borrow", bus0.borrow, 1);
    check_eq("dn_wrap_carry", bus0.carry, 0);
    for (int i = 1; i <= 7; i++) begin
      tick();
      check_eq("dn_count", bus0.count, 7 - i);
      check_eq("dn_borrow", bus0.borrow, 0);
    end

    // 3: clamped loads, priority over enable
    drive0(1'b1, 1'b0, 1'b1, 5'd31);
    tick();
    check_eq("ld31_ktop", bus0.kTop, 32'h000F_FFFF);
    check_eq("ld31_count", bus0.count, 0);
    drive0(1'b1, 1'b0, 1'b1, 5'd0);
    tick();
    check_eq("ld0_ktop", bus0.kTop, 7);
    check_eq("ld0_count", bus0.count, 0);
    drive0(1'b1, 1'b0, 1'b0, 5'd0);
    for (int i = 1; i <= 7; i++) tick();
    check_eq("pre_ld_count", bus0.count, 7);
    drive0(1'b1, 1'b0, 1'b1, 5'd2);
    tick();
    check_eq("ld_top_count", bus0.count, 0);
    check_eq("ld_top_carry", bus0.carry, 0);
    check_eq("ld_top_ktop", bus0.kTop, 7);

    // 4: midpoint reload on dut1 (k=3, kTop=15, start 7)
    drive1(1'b1, 1'b0, 1'b0, 5'd0);
    for (int i = 1; i <= 9; i++) begin
      tick();
      check_eq("mid_up_count", bus1.count, (7 + i) % 16);
      check_eq("mid_up_carry", bus1.carry, (i == 9) ? 1 : 0);
    end
    drive1(1'b0, 1'b0, 1'b1, 5'd3);
    tick();
    check_eq("mid_reload_count", bus1.count, 7);
    drive1(1'b1, 1'b1, 1'b0, 5'd0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check_eq("mid_dn_count", bus1.count, (i == 8) ? 15 : 7 - i);
      check_eq("mid_dn_borrow", bus1.borrow, (i == 8) ? 1 : 0);
    end
    drive1(1'b0, 1'b0, 1'b1, 5'd4);
    tick();
    check_eq("mid_ld4_ktop", bus1.kTop, 31);
    check_eq("mid_ld4_count", bus1.count, 15);
    drive1(1'b0, 1'b0, 1'b0, 5'd0);

    // 5: freeze with enable low, then async reset mid-count
    drive0(1'b0, 1'b0, 1'b1, 5'd3);
    tick();
    check_eq("k3_ktop", bus0.kTop, 15);
    drive0(1'b1, 1'b0, 1'b0, 5'd0);
    for (int i = 1; i <= 3; i++) tick();
    check_eq("pre_freeze_count", bus0.count, 3);
    for (int i = 0; i < 4; i++) begin
      drive0(1'b0, logic'(i % 2), 1'b0, 5'd0);
      tick();
      check_eq("frz_count", bus0.count, 3);
      check_eq("frz_carry", bus0.carry, 0);
      check_eq("frz_borrow", bus0.borrow, 0);
    end
    drive0(1'b1, 1'b0, 1'b0, 5'd0);
    for (int i = 1; i <= 5; i++) tick();
    check_eq("pre_rst_count", bus0.count, 8);
    drive0(1'b0, 1'b0, 1'b0, 5'd0);
    #2 reset = 1'b1;
    #1;
    check_eq("arst0_count", bus0.count, 0);
    check_eq("arst0_ktop", bus0.kTop, 7);
    check_eq("arst1_count", bus1.count, 7);
    check_eq("arst1_ktop", bus1.kTop, 15);
    #3 reset = 1'b0;
    tick();

`ifdef LOCK_DET_EN
    // 6: alternate up/down with k=4, lock after 16 quiet cycles
    drive0(1'b0, 1'b0, 1'b1, 5'd4);
    tick();
    check_eq("lk_ktop", bus0.kTop, 31);
    check_eq("lk_lock0", bus0.lock, 0);
    for (int i = 1; i <= 17; i++) begin
      drive0(1'b1, logic'((i % 2) == 0), 1'b0, 5'd0);
      tick();
      if (i == 16) check_eq("lk_pre", bus0.lock, 0);
      if (i == 17) check_eq("lk_set", bus0.lock, 1);
    end
    check_eq("lk_count", bus0.count, 1);
    drive0(1'b1, 1'b0, 1'b0, 5'd0);
    for (int i = 1; i <= 31; i++) begin
      tick();
      if (i == 30) check_eq("lk_hold", bus0.lock, 1);
      if (i == 31) begin
        check_eq("lk_wrap_carry", bus0.carry, 1);
        check_eq("lk_drop", bus0.lock, 0);
      end
    end
`else
    drive0(1'b1, 1'b0, 1'b0, 5'd0);
    for (int i = 1; i <= 20; i++) tick();
    check_eq("nolock0", bus0.lock, 0);
    check_eq("nolock1", bus1.lock, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
